dice_roll_scheduler: RTL and testbench

Shares one dice_roller instance among NUM_REQ requesters (player/game-logic ports). It arbitrates round-robin and drives the roller's die_select and roll pulse. It waits a fixed settle time, then samples rolled_number and range-checks the sample against the selected die. The result returns to the granted requester with a one-cycle ack. It sits between the game-control logic and dice_roller.

---
 rtl/dice_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/dice_roll_scheduler.sv | 133 +++++++++++++
 tb/tb_dice_roll_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll scheduler: die codes, die limits
// and the scheduler state encoding.
package dice_pkg;

    localparam logic [1:0] DIE_D4  = 2'd0;
    localparam logic [1:0] DIE_D6  = 2'd1;
    localparam logic [1:0] DIE_D8  = 2'd2;
    localparam logic [1:0] DIE_D20 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [7:0] die_max(input logic [1:0] code);
        logic [7:0] m;
        case (code)
            DIE_D4:  m = 8'd4;
            DIE_D6:  m = 8'd6;
            DIE_D8:  m = 8'd8;
            default: m = 8'd20;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum      = {1'b0, ptr} + (IW+1)'(gi);
            assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant_idx = cand[k];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dice_roll_scheduler.sv
// Time-shares one dice_roller between NUM_REQ requesters: round-robin grant,
// roll pulse, fixed settle wait, range-checked sample, one-cycle ack.
module dice_roll_scheduler
    import dice_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_die,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           result,
    output logic                 result_err,
    output logic                 busy,
    output logic [7:0]           err_count,
    output logic [1:0]           roller_die_select,
    output logic                 roller_roll,
    input  logic [7:0]           roller_number
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           die_q, die_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [7:0]           result_q, result_d;
    logic                 result_err_q, result_err_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 roll_q, roll_d;
    logic                 busy_q, busy_d;

    logic [IW-1:0]        grant_idx;
    logic                 grant_any;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            die_q        <= '0;
            ack_q        <= '0;
            result_q     <= '0;
            result_err_q <= 1'b0;
            err_count_q  <= '0;
            roll_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            die_q        <= die_d;
            ack_q        <= ack_d;
            result_q     <= result_d;
            result_err_q <= result_err_d;
            err_count_q  <= err_count_d;
            roll_q       <= roll_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ROLL;
            ROLL:    state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so each one is computed from the state being entered.
    always_comb begin
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        die_d        = die_q;
        ack_d        = '0;
        result_d     = result_q;
        result_err_d = result_err_q;
        err_count_d  = err_count_q;
        roll_d       = 1'b0;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    idx_d  = grant_idx;
                    die_d  = req_die[{grant_idx, 1'b0} +: 2];
                    roll_d = 1'b1;
                end
            end
            ROLL: cnt_d = CW'(SETTLE_CYCLES - 1);
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d     = roller_number;
                    result_err_d = (roller_number == 8'd0) || (roller_number > die_max(die_q));
                    ack_d[idx_q] = 1'b1;
                end
            end
            default: begin
                if (result_err_q && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end
                ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
        endcase
    end

    assign ack               = ack_q;
    assign result            = result_q;
    assign result_err        = result_err_q;
    assign busy              = busy_q;
    assign err_count         = err_count_q;
    assign roller_die_select = die_q;
    assign roller_roll       = roll_q;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Self-checking bench for dice_roll_scheduler with a scripted roller model
// and a transaction-level reference for arbitration, range check and error count.
module tb_dice_roll_scheduler;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_die = '0;
    logic [N-1:0]   ack;
    logic [7:0]     result;
    logic           result_err;
    logic           busy;
    logic [7:0]     err_count;
    logic [1:0]     roller_die_select;
    logic           roller_roll;
    logic [7:0]     roller_number;
    logic [7:0]     roll_val = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_errs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign roller_number = roll_val;

    dice_roll_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_die           (req_die),
        .ack               (ack),
        .result            (result),
        .result_err        (result_err),
        .busy              (busy),
        .err_count         (err_count),
        .roller_die_select (roller_die_select),
        .roller_roll       (roller_roll),
        .roller_number     (roller_number)
    );

    typedef struct {
        int         idx;
        logic [1:0] die;
        logic [7:0] val;
        logic       err;
    } vec_t;

    function automatic int die_limit(input logic [1:0] die);
        int lim [4] = '{4, 6, 8, 20};
        return lim[die];
    endfunction

    function automatic logic model_err(input logic [1:0] die, input logic [7:0] val);
        return (val == 0) || (int'(val) > die_limit(die));
    endfunction

    function automatic int exp_err_count();
        return (model_errs > 255) ? 255 : model_errs;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_errs = 0;
    endtask

    // Called at the negedge of the IDLE cycle that samples the request; waits
    // for the ack, checks it and the roll pulse, then returns at the next IDLE negedge.
    task automatic wait_ack(input int idx, input int exp_cyc, input logic [7:0] val,
                            input logic [1:0] die, input logic exp_err, input logic drop);
        int n = 0;
        int rolls = 0;
        int roll_cyc = -1;
        logic [1:0] sel = '0;
        while (ack == '0 && n < 40) begin
            @(negedge clk);
            n++;
            if (roller_roll) begin
                rolls++;
                roll_cyc = cyc;
                sel = roller_die_select;
            end
        end
        if (ack == '0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: req %0d got no ack, required ack at cycle %0d", idx, exp_cyc);
        end else begin
            $display("txn req=%0d die=%0d result=%0d err=%0d ack_cycle=%0d", idx, die, result, result_err, cyc);
            chk("ack_onehot", 32'(ack), 32'(1 << idx));
            chk("ack_cycle", 32'(cyc), 32'(exp_cyc));
            chk("result", 32'(result), 32'(val));
            chk("result_err", 32'(result_err), 32'(exp_err));
            chk("busy_done", 32'(busy), 32'd1);
            chk("roll_count", 32'(rolls), 32'd1);
            chk("roll_cycle", 32'(roll_cyc), 32'(exp_cyc - 5));
            chk("roll_die_sel", 32'(sel), 32'(die));
            chk("die_sel_held", 32'(roller_die_select), 32'(die));
        end
        if (exp_err) model_errs++;
        if (drop) req[idx] = 1'b0;
        @(negedge clk);
        chk("ack_single", 32'(ack), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("err_count", 32'(err_count), 32'(exp_err_count()));
    endtask

    vec_t tbl [10];

    initial begin
        logic [N-1:0] pend;
        logic [1:0]   dies [N];
        int           mptr;
        int           exp_idx;
        logic [7:0]   v;

        tbl[0] = '{0, 2'd3, 8'd17, 1'b0};
        tbl[1] = '{1, 2'd0, 8'd5,  1'b1};
        tbl[2] = '{2, 2'd1, 8'd0,  1'b1};
        tbl[3] = '{3, 2'd2, 8'd8,  1'b0};
        tbl[4] = '{1, 2'd2, 8'd9,  1'b1};
        tbl[5] = '{2, 2'd0, 8'd4,  1'b0};
        tbl[6] = '{0, 2'd3, 8'd20, 1'b0};
        tbl[7] = '{3, 2'd3, 8'd21, 1'b1};
        tbl[8] = '{1, 2'd1, 8'd6,  1'b0};
        tbl[9] = '{2, 2'd1, 8'd7,  1'b1};

        // Reset state held with no requests.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {ack, result, result_err, busy, err_count, roller_die_select, roller_roll}, 32'd0);
        end

        // Single-requester vectors.
        for (int i = 0; i < 10; i++) begin
            req_die[2*tbl[i].idx +: 2] = tbl[i].die;
            roll_val = tbl[i].val;
            req[tbl[i].idx] = 1'b1;
            wait_ack(tbl[i].idx, cyc + 6, tbl[i].val, tbl[i].die, tbl[i].err, 1'b1);
        end

        // All four together after reset: served 0,1,2,3, seven cycles apart.
        do_reset();
        req_die = 8'b11_10_01_00;
        roll_val = 8'd3;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_ack(i, cyc + 6, 8'd3, 2'(i), 1'b0, 1'b1);
        end

        // Fairness: after requester 1, requesters 0 and 2 together go 2 then 0.
        req_die = 8'b10_10_10_10;
        roll_val = 8'd7;
        req[1] = 1'b1;
        wait_ack(1, cyc + 6, 8'd7, 2'd2, 1'b0, 1'b1);
        req[0] = 1'b1;
        req[2] = 1'b1;
        wait_ack(2, cyc + 6, 8'd7, 2'd2, 1'b0, 1'b1);
        wait_ack(0, cyc + 6, 8'd7, 2'd2, 1'b0, 1'b1);

        // Randomized traffic against the transaction-level model.
        mptr = 1;
        pend = '0;
        for (int i = 0; i < N; i++) dies[i] = 2'd0;
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] add;
            add = N'($urandom_range(0, (1 << N) - 1));
            if (pend == '0 && add == '0) add = N'(1 << $urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) begin
                if (add[i] && !pend[i]) begin
                    dies[i] = 2'($urandom_range(0, 3));
                    req_die[2*i +: 2] = dies[i];
                end
            end
            pend = pend | add;
            req = pend;
            v = 8'($urandom_range(0, 24));
            roll_val = v;
            exp_idx = -1;
            for (int k = N - 1; k >= 0; k--) begin
                if (pend[(mptr + k) % N]) exp_idx = (mptr + k) % N;
            end
            wait_ack(exp_idx, cyc + 6, v, dies[exp_idx], model_err(dies[exp_idx], v), 1'b1);
            pend[exp_idx] = 1'b0;
            mptr = (exp_idx + 1) % N;
        end
        req = '0;
        @(negedge clk);

        // Held request with a bad roller value: error count saturates.
        req_die[1:0] = 2'd0;
        roll_val = 8'd0;
        req[0] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            wait_ack(0, cyc + 6, 8'd0, 2'd0, 1'b1, (t == 299));
        end
        chk("err_count_sat", 32'(err_count), 32'd255);

        // Reset during WAIT aborts the transaction and clears the pointer.
        do_reset();
        req_die[5:4] = 2'd0;
        roll_val = 8'd9;
        req[2] = 1'b1;
        wait_ack(2, cyc + 6, 8'd9, 2'd0, 1'b1, 1'b1);
        req[2] = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", {ack, result, result_err, busy, err_count, roller_die_select, roller_roll}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_no_ack", 32'(ack), 32'd0);
        end
        reset_n = 1'b1;
        model_errs = 0;
        roll_val = 8'd2;
        req_die[7:6] = 2'd0;
        req[3] = 1'b1;
        wait_ack(2, cyc + 6, 8'd2, 2'd0, 1'b0, 1'b1);
        wait_ack(3, cyc + 6, 8'd2, 2'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

endmodule
